axis_mash_nstage: RTL and testbench
===================================

// Module: axis_mash_nstage
// PURPOSE
//   Parametrised MASH delta-sigma requantiser: 1-3 cascaded first-order stages, WIDTH-bit signed in, DAC_BW-bit signed out.
//   Sits between axis_unco and axis_second_order_dsm_dac in each I/Q DAC chain.
//   Adds over the fixed MASH 1-1: full AXI-Stream backpressure, LFSR LSB dither, output saturation and a sticky overflow flag.
// PARAMETERS
//   WIDTH      16       input sample width, signed two's complement; must satisfy WIDTH >= DAC_BW+2
//   DAC_BW     7        output width, signed; F = WIDTH-DAC_BW fractional bits
//   N_STAGES   2        cascade order; legal values 1, 2, 3 (elaboration error otherwise)
//   LFSR_SEED  16'hACE1 reset value of the 16-bit dither LFSR; must be non-zero
// PORTS
//   aclk                in   1         clock
//   arst_n              in   1         reset, asynchronous assert, active low
//   s_axis_data_tdata   in   WIDTH     input sample x
//   s_axis_data_tvalid  in   1         input valid
//   s_axis_data_tready  out  1         input ready
//   m_axis_data_tdata   out  DAC_BW    requantised sample y, signed
//   m_axis_data_tvalid  out  1         output valid
//   m_axis_data_tready  in   1         output ready
//   cfg_dither_en       in   1         1 = add LFSR bit to stage-1 input
//   ovf_clear           in   1         one-cycle pulse clears ovf_sticky
//   ovf_sticky          out  1         set when any output sample was saturated
// BEHAVIOUR
// - Reset (async, arst_n=0): all accumulators, delayed carries, m_tdata=0, m_tvalid=0, ovf_sticky=0, LFSR=LSEED.
// - s_tready = !m_tvalid || m_tready (combinational); equals 1 after reset.
// - Accept = s_tvalid && s_tready. State (accumulators, carry delay lines, LFSR) advances only on accept.
// - Latency 1 cycle: y for an accepted x is registered on the accept edge; m_tvalid=1 next cycle.
// - m_tvalid cleared when m_tready=1 and no accept in that cycle; m_tdata/m_tvalid held stable while m_tvalid && !m_tready.
// - Split: coarse c = x[WIDTH-1:F] (signed DAC_BW), fraction f = x[F-1:0] (unsigned F).
// - d = cfg_dither_en ? lfsr[0] : 0. LFSR Galois x^16+x^14+x^13+x^11, shifts once per accept.
// - Stage 1: s1 = acc1 + f + d (F+1 bits); c1 = s1[F]; e1 = s1[F-1:0]; acc1 <= e1.
// - Stage k>1: sk = acck + e(k-1); ck = sk[F]; ek = sk[F-1:0]; acck <= ek.
// - Combination (n = this accept, n-1/n-2 = previous accepts):
//     N=1: t = c1
//     N=2: t = c1 + c2[n] - c2[n-1]
//     N=3: t = N=2 term + c3[n] - 2*c3[n-1] + c3[n-2]
//   t range: N=1 [0,1], N=2 [-1,2], N=3 [-3,4].
// - Sum: z = c + t computed in DAC_BW+3 bits; y = saturate(z) to [-2^(DAC_BW-1), 2^(DAC_BW-1)-1].
// - ovf_sticky <= 1 on accept where z out of range; ovf_clear clears it; set and clear in same cycle -> set wins.
// - cfg_dither_en sampled on each accept; toggling mid-stream needs no flush.
// - No state reset other than arst_n; reset mid-stream drops the pending output and restarts from seed.
// - Parameter check: N_STAGES outside 1..3 or WIDTH < DAC_BW+2 -> $error at elaboration.
// TESTING (WIDTH=16, DAC_BW=7, F=9, dither off unless stated, m_tready=1 unless stated)
// 1 Zero fraction: x=16'h0600 (c=3,f=0), N_STAGES=1/2/3 -> y=3 every cycle, latency 1, ovf_sticky=0.
// 2 Quarter fraction, N=1: x=16'h0680 (c=3,f=128) stream -> y = 3,3,3,4 repeating; first 4 on 4th accept.
// 3 Mean accuracy, N=2 and N=3: x=16'h0680 for 512 accepts -> sum(y) = 512*3+128 exactly; y within [1,7].
// 4 Backpressure: m_tready low 5 cycles mid-stream -> s_tready=0, m_tdata frozen; resumed sequence identical to run 2.
// 5 Saturation: x=16'h7FFF, N=3 -> y never > 63, ovf_sticky=1; ovf_clear pulse coincident with new overflow -> stays 1.
// 6 Reset mid-stream + dither: assert arst_n=0 for 1 cycle -> m_tvalid=0, m_tdata=0 immediately; with dither on,
//   x=16'h0600 -> y in {3,4}, sequence bit-matches model seeded 16'hACE1.

Source files
------------

// File: rtl/axis_mash_nstage.sv
// MASH delta-sigma requantiser with 1-3 cascaded first-order stages.
// Takes WIDTH-bit signed samples and produces DAC_BW-bit signed samples, with
// AXI-Stream backpressure, optional LFSR dither on the stage-1 LSB, output
// saturation and a sticky overflow flag.
module axis_mash_nstage #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DAC_BW    = 7,
  parameter int unsigned N_STAGES  = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              aclk,
  input  logic              arst_n,
  input  logic [WIDTH-1:0]  s_axis_data_tdata,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  output logic [DAC_BW-1:0] m_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  input  logic              cfg_dither_en,
  input  logic              ovf_clear,
  output logic              ovf_sticky
);

  localparam int unsigned F  = WIDTH - DAC_BW;
  localparam int unsigned ZW = DAC_BW + 3;
  localparam int YMaxI = (2 ** (DAC_BW - 1)) - 1;
  localparam int YMinI = -(2 ** (DAC_BW - 1));
  localparam logic signed [ZW-1:0] YMax = ZW'(YMaxI);
  localparam logic signed [ZW-1:0] YMin = ZW'(YMinI);

  if (N_STAGES < 1 || N_STAGES > 3 || WIDTH < DAC_BW + 2 || LFSR_SEED == 16'h0000)
  begin : g_param_err
    $error("axis_mash_nstage: illegal parameter combination");
  end

  logic [F-1:0]  acc1_q, acc2_q, acc3_q;
  logic          c2_q, c3_q, c3_qq;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [DAC_BW-1:0] y_q, y_d;
  logic          valid_q, ovf_q;

  logic signed [DAC_BW-1:0] coarse;
  logic [F-1:0]  frac;
  logic          dith;
  logic [F:0]    s1, s2, s3;
  logic signed [3:0]    t;
  logic signed [ZW-1:0] z;
  logic          oor;
  logic          accept;

  assign s_axis_data_tready = !valid_q || m_axis_data_tready;
  assign accept             = s_axis_data_tvalid && s_axis_data_tready;
  assign m_axis_data_tdata  = y_q;
  assign m_axis_data_tvalid = valid_q;
  assign ovf_sticky         = ovf_q;

  assign coarse = s_axis_data_tdata[WIDTH-1:F];
  assign frac   = s_axis_data_tdata[F-1:0];
  assign dith   = cfg_dither_en & lfsr_q[0];

  // Cascade: each stage integrates the previous stage's residue; carry is the MSB.
  assign s1 = {1'b0, acc1_q} + {1'b0, frac} + {{F{1'b0}}, dith};
  assign s2 = {1'b0, acc2_q} + {1'b0, s1[F-1:0]};
  assign s3 = {1'b0, acc3_q} + {1'b0, s2[F-1:0]};

  // Galois LFSR, taps x^16+x^14+x^13+x^11.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Noise-cancelling combination of the stage carries, then saturating add to the coarse part.
  always_comb begin
    t = {3'b000, s1[F]};
    if (N_STAGES >= 2) begin
      t = t + {3'b000, s2[F]} - {3'b000, c2_q};
    end
    if (N_STAGES >= 3) begin
      t = t + {3'b000, s3[F]} - {2'b00, c3_q, 1'b0} + {3'b000, c3_qq};
    end
    z   = {{3{coarse[DAC_BW-1]}}, coarse} + {{(ZW-4){t[3]}}, t};
    oor = 1'b0;
    y_d = z[DAC_BW-1:0];
    if (z > YMax) begin
      y_d = YMax[DAC_BW-1:0];
      oor = 1'b1;
    end else if (z < YMin) begin
      y_d = YMin[DAC_BW-1:0];
      oor = 1'b1;
    end
  end

  // Modulator state advances only on an accepted input sample.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      acc1_q <= '0;
      acc2_q <= '0;
      acc3_q <= '0;
      c2_q   <= 1'b0;
      c3_q   <= 1'b0;
      c3_qq  <= 1'b0;
      lfsr_q <= LFSR_SEED;
    end else if (accept) begin
      acc1_q <= s1[F-1:0];
      acc2_q <= s2[F-1:0];
      acc3_q <= s3[F-1:0];
      c2_q   <= s2[F];
      c3_qq  <= c3_q;
      c3_q   <= s3[F];
      lfsr_q <= lfsr_d;
    end
  end

  // Output register: load on accept, drop valid once consumed, hold while stalled.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      y_q     <= y_d;
      valid_q <= 1'b1;
    end else if (m_axis_data_tready) begin
      valid_q <= 1'b0;
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      ovf_q <= 1'b0;
    end else if (accept && oor) begin
      ovf_q <= 1'b1;
    end else if (ovf_clear) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_mash_nstage.sv
// Bench for axis_mash_nstage: three instances (N_STAGES=1,2,3) share one input
// stream and are compared against an arithmetic MASH model every cycle.
module tb_axis_mash_nstage;

  logic        aclk = 1'b0;
  logic        arst_n = 1'b0;
  logic [15:0] sx = '0;
  logic        sv = 1'b0, mr = 1'b1, dith = 1'b0, oclr = 1'b0;
  logic        srdy [3];
  logic [6:0]  mdat [3];
  logic        mval [3];
  logic        ovf  [3];

  always #5 aclk = ~aclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    axis_mash_nstage #(
      .WIDTH(16), .DAC_BW(7), .N_STAGES(g + 1), .LFSR_SEED(16'hACE1)
    ) u_dut (
      .aclk               (aclk),
      .arst_n             (arst_n),
      .s_axis_data_tdata  (sx),
      .s_axis_data_tvalid (sv),
      .s_axis_data_tready (srdy[g]),
      .m_axis_data_tdata  (mdat[g]),
      .m_axis_data_tvalid (mval[g]),
      .m_axis_data_tready (mr),
      .cfg_dither_en      (dith),
      .ovf_clear          (oclr),
      .ovf_sticky         (ovf[g])
    );
  end

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state (instance i has i+1 stages)
  int          macc [3][3];
  int          p2 [3], p3a [3], p3b [3];
  logic [15:0] mlfsr;
  bit          e_valid;
  int          e_data [3];
  bit          e_ovf [3];
  bit          last_acc;

  typedef struct {
    logic [15:0] x;
    int y1;
    int y2;
    int y3;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) macc[i][k] = 0;
      p2[i] = 0; p3a[i] = 0; p3b[i] = 0;
      e_data[i] = 0; e_ovf[i] = 0;
    end
    mlfsr   = 16'hACE1;
    e_valid = 0;
  endtask

  task automatic model_edge(input bit acc);
    int xs, cc, f, d, e, s, t, z;
    int cr [3];
    if (acc) begin
      xs = int'($signed(sx));
      cc = xs >>> 9;
      f  = xs & 511;
      d  = dith ? int'(mlfsr[0]) : 0;
      for (int i = 0; i < 3; i++) begin
        cr = '{0, 0, 0};
        e  = f + d;
        for (int k = 0; k <= i; k++) begin
          s = macc[i][k] + e;
          cr[k] = (s >= 512) ? 1 : 0;
          macc[i][k] = s % 512;
          e = s % 512;
        end
        t = cr[0];
        if (i >= 1) t += cr[1] - p2[i];
        if (i >= 2) t += cr[2] - 2 * p3a[i] + p3b[i];
        p2[i] = cr[1]; p3b[i] = p3a[i]; p3a[i] = cr[2];
        z = cc + t;
        e_data[i] = (z > 63) ? 63 : (z < -64) ? -64 : z;
        if (z > 63 || z < -64) e_ovf[i] = 1;
        else if (oclr) e_ovf[i] = 0;
      end
      mlfsr   = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
      e_valid = 1;
    end else begin
      for (int i = 0; i < 3; i++) if (oclr) e_ovf[i] = 0;
      if (mr) e_valid = 0;
    end
  endtask

  // One clock: drive inputs, check ready, clock, compare all instances to the model.
  task automatic cycle(input logic [15:0] x, input bit v, input bit r, input bit di,
                       input bit cl);
    bit exp_rdy;
    sx = x; sv = v; mr = r; dith = di; oclr = cl;
    #1;
    exp_rdy = !e_valid || r;
    for (int g = 0; g < 3; g++) chk($sformatf("tready N%0d", g + 1), srdy[g], exp_rdy);
    last_acc = v && exp_rdy;
    @(posedge aclk);
    model_edge(last_acc);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("tvalid N%0d", g + 1), mval[g], e_valid);
      chk($sformatf("tdata N%0d", g + 1), int'($signed(mdat[g])), e_data[g]);
      chk($sformatf("ovf N%0d", g + 1), ovf[g], e_ovf[g]);
    end
  endtask

  task automatic do_reset();
    sv = 0; oclr = 0;
    arst_n = 1'b0;
    #1;
    model_reset();
    for (int g = 0; g < 3; g++) begin
      chk("reset tvalid", mval[g], 0);
      chk("reset tdata", int'(mdat[g]), 0);
      chk("reset ovf", ovf[g], 0);
      chk("reset tready", srdy[g], 1);
    end
    @(posedge aclk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    int k, sum2, sum3, bad, held;
    logic [15:0] rx;

    for (int i = 0; i < 4; i++) tbl[i] = '{16'h0600, 3, 3, 3};
    for (int i = 4; i < 12; i++) tbl[i] = '{16'h0680, ((i - 4) % 4 == 3) ? 4 : 3, -1, -1};

    // Zero fraction then quarter fraction from reset
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].x, 1, 1, 0, 0);
      chk("table y N1", int'($signed(mdat[0])), tbl[i].y1);
      if (tbl[i].y2 >= 0) chk("table y N2", int'($signed(mdat[1])), tbl[i].y2);
      if (tbl[i].y3 >= 0) chk("table y N3", int'($signed(mdat[2])), tbl[i].y3);
      if (i < 4) chk("table ovf N3", ovf[2], 0);
    end

    // Mean accuracy over 512 accepts
    do_reset();
    sum2 = 0; sum3 = 0; bad = 0;
    for (int i = 0; i < 512; i++) begin
      cycle(16'h0680, 1, 1, 0, 0);
      sum2 += int'($signed(mdat[1]));
      sum3 += int'($signed(mdat[2]));
      if ($signed(mdat[1]) < 1 || $signed(mdat[1]) > 7) bad++;
      if ($signed(mdat[2]) < 1 || $signed(mdat[2]) > 7) bad++;
    end
    chk("mean sum N2", sum2, 512 * 3 + 128);
    chk("mean sum N3", sum3, 512 * 3 + 128);
    chk("mean range", bad, 0);

    // Backpressure mid-stream
    do_reset();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      bit r;
      r = !(c >= 6 && c < 11);
      held = int'(mdat[0]);
      cycle(16'h0680, 1, r, 0, 0);
      if (!r) begin
        chk("bp frozen", int'(mdat[0]), held);
        chk("bp tready low", srdy[0], 0);
      end
      if (last_acc) begin
        chk("bp seq", int'($signed(mdat[0])), (k % 4 == 3) ? 4 : 3);
        k++;
      end
    end
    chk("bp accepts", k, 15);

    // Saturation and set-beats-clear
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cycle(16'h7FFF, 1, 1, 0, c == 10);
      if (c == 10) chk("ovf set wins", ovf[0], 1);
      if (c >= 1) chk("sat y N1", int'($signed(mdat[0])), 63);
      chk("sat no wrap N3", int'($signed(mdat[2])) >= 60, 1);
    end
    chk("sat ovf N3", ovf[2], 1);
    cycle(16'h7FFF, 0, 1, 0, 1);
    chk("ovf cleared", ovf[0], 0);

    // Mid-stream reset, then dithered stream from seed
    for (int c = 0; c < 5; c++) cycle(16'h1234 + 16'(c * 77), 1, 1, 0, 0);
    do_reset();
    for (int c = 0; c < 64; c++) begin
      cycle(16'h0600, 1, 1, 1, 0);
      chk("dither range", (mdat[0] == 7'd3 || mdat[0] == 7'd4) ? 1 : 0, 1);
    end

    // Randomised traffic against the model
    for (int c = 0; c < 1500; c++) begin
      rx = 16'($urandom);
      if ($urandom_range(0, 5) == 0) rx = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
      cycle(rx, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
